// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO behind the decoder strobes.
// Latency: a byte captured at edge E0 starts its start bit after E1; each frame is 10*CLKS_PER_BIT cycles.
// Backpressure: none on the bus; firmware polls ready, and a write into a full FIFO is dropped and sets sticky overflow.
//
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   uart_write        data-register store strobe; wdata[7:0] is the byte
//   uart_status_read  status-register load strobe; rdata is valid the same cycle
//   wdata             CPU store data (upper 24 bits ignored)
//   rdata             {29'b0, overflow, busy, ready} while uart_status_read, else 0
//   tx                serial line, idle high, registered
module uart_tx_periph #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_write,
  input  logic        uart_status_read,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;
  logic               overflow;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW:0]   wr_ptr;
  logic [FIFO_AW:0]   rd_ptr;

  logic               full;
  logic               empty;
  logic               busy;
  logic               bit_end;
  logic               push;
  logic               pop;
  logic [7:0]         head;

  logic               unused_wdata_hi;
  assign unused_wdata_hi = ^wdata[31:8];

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[FIFO_AW-1:0]];

  assign bit_end = (cnt == CNT_LAST);
  // Full is judged on pre-edge state, so a same-cycle pop never makes room for a write.
  assign push    = uart_write && !full;
  // STOP pops directly into the next START so back-to-back frames have no idle gap.
  assign pop     = !empty && ((state == IDLE) || ((state == STOP) && bit_end));

  assign busy  = (state != IDLE) || !empty;
  assign rdata = uart_status_read ? {29'd0, overflow, busy, !full} : 32'd0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // A dropped write in the same cycle as a status read keeps the flag set.
      if (uart_write && full) begin
        overflow <= 1'b1;
      end else if (uart_status_read) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            shreg <= head;
            tx    <= 1'b0;
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx      <= shreg[0];
            bit_idx <= '0;
            cnt     <= '0;
            state   <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              // shreg[0] is on the line now; the next bit is shreg[1].
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (!empty) begin
              shreg <= head;
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph with CLKS_PER_BIT=4, FIFO_AW=2.
// Stimulus pushes expected frames and status words into queues; monitors pop and compare.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_uart_tx_periph;

  localparam int CPB = 4;

  typedef struct {
    logic [7:0] data;
    int         start;
    bit         abort;
  } frame_t;

  logic        clk;
  logic        rst_n;
  logic        uart_write;
  logic        uart_status_read;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  frame_t      fq[$];
  logic [31:0] sq[$];

  uart_tx_periph #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .uart_write       (uart_write),
    .uart_status_read (uart_status_read),
    .wdata            (wdata),
    .rdata            (rdata),
    .tx               (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Status monitor: every read strobe must match the next queued status word.
  logic [31:0] sexp;
  always @(negedge clk) begin
    if (uart_status_read === 1'b1) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL status_unexpected cyc=%0d actual=%h required=no_read", cyc, rdata);
      end else begin
        sexp = sq.pop_front();
        if (rdata !== sexp) begin
          errors++;
          $display("FAIL status cyc=%0d actual=%h required=%h", cyc, rdata, sexp);
        end
      end
    end
  end

  // Line must be idle high whenever reset is asserted.
  always @(negedge clk) begin
    if (rst_n === 1'b0) begin
      checks++;
      if (tx !== 1'b1) begin
        errors++;
        $display("FAIL tx_in_reset cyc=%0d actual=%b required=1", cyc, tx);
      end
    end
  end

  // Frame monitor: every cycle of a frame is compared against {stop, data, start}.
  initial begin : frame_mon
    frame_t     e;
    logic [9:0] fr;
    int         bad;
    bit         ab;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        if (fq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected cyc=%0d actual=start_bit required=idle", cyc);
          while (rst_n === 1'b1 && tx === 1'b0) @(negedge clk);
        end else begin
          e = fq.pop_front();
          checks++;
          if (cyc != e.start) begin
            errors++;
            $display("FAIL frame_start data=%h actual=%0d required=%0d", e.data, cyc, e.start);
          end
          fr  = {1'b1, e.data, 1'b0};
          bad = 0;
          ab  = 1'b0;
          for (int i = 0; i < 10 * CPB; i++) begin
            if (i > 0) @(negedge clk);
            if (rst_n !== 1'b1) begin
              ab = 1'b1;
              if (tx !== 1'b1) bad++;
              break;
            end
            if (tx !== fr[i / CPB]) bad++;
          end
          checks++;
          if (bad != 0 || ab != e.abort) begin
            errors++;
            $display("FAIL frame_bits data=%h actual_bad=%0d aborted=%0b required_bad=0 aborted=%0b",
                     e.data, bad, ab, e.abort);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wr(input logic [7:0] b);
    uart_write = 1'b1;
    wdata      = {24'hA5C3E1, b};
    tick();
    uart_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] e);
    uart_status_read = 1'b1;
    sq.push_back(e);
    tick();
    uart_status_read = 1'b0;
  endtask

  task automatic exp_frame(input logic [7:0] d, input int s, input bit a);
    frame_t f;
    f.data  = d;
    f.start = s;
    f.abort = a;
    fq.push_back(f);
  endtask

  int k;

  initial begin : stim
    rst_n            = 1'b0;
    uart_write       = 1'b0;
    uart_status_read = 1'b0;
    wdata            = 32'd0;
    tick();
    tick();

    // Strobes toggling in reset: no FIFO effect, status reads ready only.
    for (int i = 0; i < 6; i++) begin
      uart_write       = i[0];
      wdata            = 32'h000000EE;
      uart_status_read = (i == 1 || i == 3 || i == 4);
      if (uart_status_read) sq.push_back(32'h1);
      tick();
    end
    uart_write       = 1'b0;
    uart_status_read = 1'b0;
    rst_n = 1'b1;
    tick();
    rd(32'h1);

    // Single byte 0x55, busy boundaries around the stop bit.
    k = cyc;
    exp_frame(8'h55, k + 2, 1'b0);
    wr(8'h55);
    rd(32'h3);
    wait_until(k + 10);
    rd(32'h3);
    wait_until(k + 41);
    rd(32'h3);
    rd(32'h1);

    // Back-to-back bytes: second start bit immediately follows first stop bit.
    k = cyc;
    exp_frame(8'hA5, k + 2, 1'b0);
    exp_frame(8'h0F, k + 2 + 10 * CPB, 1'b0);
    wr(8'hA5);
    wr(8'h0F);
    wait_until(k + 81);
    rd(32'h3);
    rd(32'h1);

    // Overflow: 0x01 popped, 0x02..0x05 fill, 0x06 dropped.
    k = cyc;
    for (int i = 0; i < 5; i++) exp_frame(8'(i + 1), k + 2 + 10 * CPB * i, 1'b0);
    for (int i = 1; i <= 6; i++) wr(8'(i));
    rd(32'h6);
    rd(32'h2);
    // Read + write into full FIFO: pre-edge status, write dropped, overflow set wins.
    uart_write       = 1'b1;
    wdata            = 32'h00000077;
    uart_status_read = 1'b1;
    sq.push_back(32'h2);
    tick();
    uart_write       = 1'b0;
    uart_status_read = 1'b0;
    rd(32'h6);
    rd(32'h2);
    // Ready returns the cycle after the first pop out of the full FIFO.
    wait_until(k + 41);
    rd(32'h2);
    rd(32'h3);
    wait_until(k + 201);
    rd(32'h3);
    rd(32'h1);

    // Reset during data bit 3 with a second byte queued behind it.
    k = cyc;
    exp_frame(8'h00, k + 2, 1'b1);
    wr(8'h00);
    wr(8'h3C);
    wait_until(k + 19);
    #2;
    rst_n = 1'b0;
    tick();
    tick();
    rd(32'h1);
    rst_n = 1'b1;
    tick();
    rd(32'h1);
    repeat (50) tick();
    rd(32'h1);

    repeat (2) tick();
    checks++;
    if (fq.size() != 0) begin
      errors++;
      $display("FAIL frames_pending actual=%0d required=0", fq.size());
    end
    checks++;
    if (sq.size() != 0) begin
      errors++;
      $display("FAIL status_pending actual=%0d required=0", sq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
